rect_skey_pingpong: RTL

//  Parametrised, double-buffered round-key store for the RECTANGLE/Blowfish cores.
//  The key scheduler fills a shadow bank while the cipher core reads the active bank.

---
 rtl/rect_skey_pkg.sv | 38 +++
 rtl/rect_skey_bank.sv | 80 ++++++++
 rtl/rect_skey_pingpong.sv | 134 +++++++++++++
 3 files changed

// File: rtl/rect_skey_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rect_skey_pkg
// Purpose : Shared definitions for the RECTANGLE/Blowfish round-key store.
//           Default subkey geometry, bank-select encoding and a constant
//           ceil(log2) helper used to size address ports.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package rect_skey_pkg;

  // RECTANGLE-128 runs 25 rounds plus a final whitening key.
  localparam int RECTANGLE128_NKEYS = 26;
  localparam int DEF_KEY_W          = 64;
  localparam int DEF_NKEYS          = RECTANGLE128_NKEYS;

  // Which physical bank the cipher core is currently reading.
  typedef enum logic {
    BANK0 = 1'b0,
    BANK1 = 1'b1
  } bank_sel_e;

  // Constant ceil(log2(n)), never less than 1 so a port width is always legal.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage : rect_skey_pkg
`default_nettype wire

// File: rtl/rect_skey_bank.sv
`default_nettype none
// ============================================================================
// Module  : rect_skey_bank
// Purpose : One round-key bank: NKEYS x KEY_W storage, per-entry fill bitmap
//           and a bank-valid flag. Storage has no reset so it can map to RAM;
//           only the bookkeeping flops are reset.
// Ports   : clk, rst        clock, asynchronous active-high reset
//           we/waddr/wdata  write port (caller guarantees bank is shadow)
//           bmp_clr         clear the whole fill bitmap
//           valid_set/clr   set / clear the bank-valid flag (clear wins)
//           raddr/rdata     combinational read port
//           full            every entry has been written since last clear
//           valid           bank holds a complete, published key set
// Rev     : 1.0  initial release
// ============================================================================
module rect_skey_bank
  import rect_skey_pkg::*;
#(
  parameter int KEY_W = DEF_KEY_W,
  parameter int NKEYS = DEF_NKEYS,
  parameter int AW    = clog2(DEF_NKEYS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [KEY_W-1:0] wdata,
  input  logic             bmp_clr,
  input  logic             valid_set,
  input  logic             valid_clr,
  input  logic [AW-1:0]    raddr,
  output logic [KEY_W-1:0] rdata,
  output logic             full,
  output logic             valid
);

  localparam logic [AW:0] NK_EXT = (AW+1)'(NKEYS);

  logic [KEY_W-1:0] mem [NKEYS];
  logic [NKEYS-1:0] bitmap;
  logic             waddr_ok;
  logic             raddr_ok;

  // Extra top bit keeps the compare correct when NKEYS == 2**AW.
  assign waddr_ok = ({1'b0, waddr} < NK_EXT);
  assign raddr_ok = ({1'b0, raddr} < NK_EXT);

  always_ff @(posedge clk) begin
    if (we && waddr_ok) begin
      mem[waddr] <= wdata;
    end
  end

  // A clear in the same cycle as a write wins: the aborted fill must not
  // leave a stray bit behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bitmap <= '0;
    end else if (bmp_clr) begin
      bitmap <= '0;
    end else if (we && waddr_ok) begin
      bitmap[waddr] <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
    end else if (valid_clr) begin
      valid <= 1'b0;
    end else if (valid_set) begin
      valid <= 1'b1;
    end
  end

  assign full  = &bitmap;
  assign rdata = raddr_ok ? mem[raddr] : '0;

endmodule : rect_skey_bank
`default_nettype wire

// File: rtl/rect_skey_pingpong.sv
`default_nettype none
// ============================================================================
// Module  : rect_skey_pingpong
// Purpose : Double-buffered round-key store. The key scheduler fills the
//           shadow bank while the cipher core reads the active bank; a full
//           shadow bank is published by swapping banks when the core is idle
//           (or immediately if no key set is active yet).
// Ports   : Clk          clock
//           flush        asynchronous active-high reset
//           WE/WAddr/KeyIn  shadow-bank write port
//           wr_abort     discard the partial shadow fill
//           core_idle    core between blocks, swap allowed
//           RE/RAddr/dec read request; dec reverses the round order
//           KeyOut/KeyValid  registered read data, one cycle after RE
//           skey_ready   active bank holds a complete key set
//           shadow_full  all shadow entries written
//           swap_pulse   one-cycle pulse after a bank swap
//           werr         one-cycle pulse after a write to an illegal index
// Rev     : 1.0  initial release
// ============================================================================
module rect_skey_pingpong
  import rect_skey_pkg::*;
#(
  parameter int KEY_W = DEF_KEY_W,
  parameter int NKEYS = DEF_NKEYS,
  parameter int AW    = clog2(DEF_NKEYS)
) (
  input  logic             Clk,
  input  logic             flush,
  input  logic             WE,
  input  logic [AW-1:0]    WAddr,
  input  logic [KEY_W-1:0] KeyIn,
  input  logic             wr_abort,
  input  logic             core_idle,
  input  logic             RE,
  input  logic [AW-1:0]    RAddr,
  input  logic             dec,
  output logic [KEY_W-1:0] KeyOut,
  output logic             KeyValid,
  output logic             skey_ready,
  output logic             shadow_full,
  output logic             swap_pulse,
  output logic             werr
);

  localparam logic [AW:0]   NK_EXT = (AW+1)'(NKEYS);
  localparam logic [AW-1:0] NK_M1  = AW'(NKEYS - 1);

  bank_sel_e        act_sel;
  logic             act_bit;
  logic             waddr_ok;
  logic             raddr_ok;
  logic             wr_ok;
  logic             swap;
  logic             read_ok;
  logic [AW-1:0]    phys_idx;
  logic [KEY_W-1:0] act_rdata;
  logic [1:0]       bank_full;
  logic [1:0]       bank_valid;
  logic [KEY_W-1:0] bank_rdata [2];

  assign act_bit  = act_sel;
  assign waddr_ok = ({1'b0, WAddr} < NK_EXT);
  assign raddr_ok = ({1'b0, RAddr} < NK_EXT);

  // Abort outranks a same-cycle write so the shadow really ends up empty.
  assign wr_ok = WE && waddr_ok && !wr_abort;

  // Decrypt walks the schedule backwards. Wraps mod 2**AW, but any RAddr
  // that would go negative is already rejected by raddr_ok.
  assign phys_idx = dec ? (NK_M1 - RAddr) : RAddr;

  assign shadow_full = act_bit ? bank_full[0]  : bank_full[1];
  assign skey_ready  = act_bit ? bank_valid[1] : bank_valid[0];
  assign act_rdata   = act_bit ? bank_rdata[1] : bank_rdata[0];

  // Hold the swap off while the scheduler is still touching the shadow bank.
  // With no active key set there is nothing to protect, so core_idle is
  // not needed for the first load.
  assign swap = shadow_full && !WE && !wr_abort && (core_idle || !skey_ready);

  // The valid gate keeps stale or never-written storage off KeyOut.
  assign read_ok = RE && raddr_ok && skey_ready;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    logic is_act;
    assign is_act = (act_bit == 1'(b));

    // On a swap the outgoing active bank becomes the new shadow, so its
    // bitmap and valid flag are cleared in the same edge.
    rect_skey_bank #(
      .KEY_W (KEY_W),
      .NKEYS (NKEYS),
      .AW    (AW)
    ) u_bank (
      .clk       (Clk),
      .rst       (flush),
      .we        (wr_ok && !is_act),
      .waddr     (WAddr),
      .wdata     (KeyIn),
      .bmp_clr   ((wr_abort && !is_act) || (swap && is_act)),
      .valid_set (swap && !is_act),
      .valid_clr (swap && is_act),
      .raddr     (phys_idx),
      .rdata     (bank_rdata[b]),
      .full      (bank_full[b]),
      .valid     (bank_valid[b])
    );
  end

  always_ff @(posedge Clk or posedge flush) begin
    if (flush) begin
      act_sel    <= BANK0;
      swap_pulse <= 1'b0;
      werr       <= 1'b0;
      KeyValid   <= 1'b0;
      KeyOut     <= '0;
    end else begin
      swap_pulse <= swap;
      werr       <= WE && !waddr_ok;
      if (swap) begin
        act_sel <= bank_sel_e'(~act_bit);
      end
      // Reads in the swap cycle still see the pre-swap bank because
      // act_sel only changes at this same edge.
      KeyValid <= read_ok;
      if (RE) begin
        KeyOut <= read_ok ? act_rdata : '0;
      end
    end
  end

endmodule : rect_skey_pingpong
`default_nettype wire
